// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and bus-slicing helper for the multi-port register file.
package regfile_pkg;

   localparam int XLEN          = 32;
   localparam int NUM_ARCH_REGS = 32;
   localparam int REG_ZERO      = 0;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } rf_state_e;

   // Low bit of lane idx in a packed bus built from lanes of the given width.
   function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of regfile_mp: packed read, write and scoreboard-set ports.
interface regfile_mp_if #(
   parameter int  WORD_SIZE = 32,
   parameter int  NUM_REGS  = 32,
   parameter int  NUM_RD    = 2,
   parameter int  NUM_WR    = 1,
   localparam int AW        = $clog2(NUM_REGS)
);
   logic [NUM_RD*AW-1:0]        rd_addr;
   logic [NUM_RD*WORD_SIZE-1:0] rd_data;
   logic [NUM_RD-1:0]           rd_busy;
   logic [NUM_WR-1:0]           wr_en;
   logic [NUM_WR*AW-1:0]        wr_addr;
   logic [NUM_WR*WORD_SIZE-1:0] wr_data;
   logic                        sb_set_en;
   logic [AW-1:0]               sb_set_addr;
   logic                        init_done;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      input  rd_data, rd_busy, init_done
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      output rd_data, rd_busy, init_done
   );
endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset clear sweep: walks every register index once, then parks in READY.
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int  NUM_REGS = NUM_ARCH_REGS,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          clear_en_o,
   output logic [AW-1:0] clear_addr_o,
   output logic          init_done_o
);
   rf_state_e     state_q;
   logic [AW-1:0] idx_q;
   logic          done_q;

   // Sweep FSM; reset restarts the sweep from index 0 even mid-sweep.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_CLEAR;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (idx_q == AW'(NUM_REGS - 1)) begin
                  state_q <= ST_READY;
                  idx_q   <= '0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 1'b1;
               end
            end
            ST_READY: begin
               done_q <= 1'b1;
            end
            default: begin
               state_q <= ST_CLEAR;
               idx_q   <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clear_en_o   = (state_q == ST_CLEAR);
   assign clear_addr_o = idx_q;
   assign init_done_o  = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int  WORD_SIZE = XLEN,
   parameter int  NUM_REGS  = NUM_ARCH_REGS,
   parameter int  NUM_RD    = 2,
   parameter int  NUM_WR    = 1,
   parameter int  ZERO_REG  = 1,
   localparam int AW        = $clog2(NUM_REGS)
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);
   logic                        clear_en_s;
   logic [AW-1:0]               clear_addr_s;
   logic                        init_done_s;
   logic [WORD_SIZE-1:0]        mem_q [NUM_REGS];
   logic [NUM_REGS-1:0]         busy_q;
   logic [NUM_REGS-1:0]         busy_d;
   logic [NUM_RD*WORD_SIZE-1:0] rd_data_s;
   logic [NUM_RD-1:0]           rd_busy_s;
   logic [AW-1:0]               ra_s;

   function automatic logic is_hardwired(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == AW'(REG_ZERO));
   endfunction

   regfile_init_seq #(.NUM_REGS(NUM_REGS)) u_init_seq (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_en_o   (clear_en_s),
      .clear_addr_o (clear_addr_s),
      .init_done_o  (init_done_s)
   );

   // Storage: sweep clear has priority; later write ports override earlier ones.
   always_ff @(posedge clk) begin
      if (clear_en_s) begin
         mem_q[clear_addr_s] <= '0;
      end else if (!rst) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && !is_hardwired(bus.wr_addr[lane_lo(j, AW) +: AW])) begin
               mem_q[bus.wr_addr[lane_lo(j, AW) +: AW]] <= bus.wr_data[lane_lo(j, WORD_SIZE) +: WORD_SIZE];
            end
         end
      end
   end

   // Scoreboard next state: writes retire, a new producer's set wins over retirement.
   always_comb begin
      busy_d = busy_q;
      if (!clear_en_s) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j]) begin
               busy_d[bus.wr_addr[lane_lo(j, AW) +: AW]] = 1'b0;
            end else begin
               busy_d = busy_d;
            end
         end
         if (bus.sb_set_en) begin
            busy_d[bus.sb_set_addr] = 1'b1;
         end else begin
            busy_d = busy_d;
         end
      end else begin
         busy_d = busy_q;
      end
      busy_d[0] = (ZERO_REG != 0) ? 1'b0 : busy_d[0];
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Read ports: storage lookup, optionally overridden by same-cycle writes.
   always_comb begin
      rd_data_s = '0;
      rd_busy_s = '0;
      ra_s      = '0;
      if (!clear_en_s) begin
         for (int k = 0; k < NUM_RD; k++) begin
            ra_s = bus.rd_addr[lane_lo(k, AW) +: AW];
            if (is_hardwired(ra_s)) begin
               rd_data_s[lane_lo(k, WORD_SIZE) +: WORD_SIZE] = '0;
               rd_busy_s[k] = 1'b0;
            end else begin
               rd_data_s[lane_lo(k, WORD_SIZE) +: WORD_SIZE] = mem_q[ra_s];
               rd_busy_s[k] = busy_q[ra_s];
`ifdef RF_BYPASS_EN
               for (int j = 0; j < NUM_WR; j++) begin
                  if (bus.wr_en[j] && (bus.wr_addr[lane_lo(j, AW) +: AW] == ra_s)) begin
                     rd_data_s[lane_lo(k, WORD_SIZE) +: WORD_SIZE] =
                        bus.wr_data[lane_lo(j, WORD_SIZE) +: WORD_SIZE];
                     rd_busy_s[k] = bus.sb_set_en && (bus.sb_set_addr == ra_s);
                  end else begin
                     rd_busy_s[k] = rd_busy_s[k];
                  end
               end
`else
               rd_busy_s[k] = rd_busy_s[k];
`endif
            end
         end
      end else begin
         rd_data_s = '0;
         rd_busy_s = '0;
      end
   end

   assign bus.rd_data   = rd_data_s;
   assign bus.rd_busy   = rd_busy_s;
   assign bus.init_done = init_done_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (two read ports, two write ports) with a queue-based scoreboard.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int WS  = 32;
   localparam int NR  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;
   localparam int AW  = 5;

   logic clk;
   logic rst;

   regfile_mp_if #(.WORD_SIZE(WS), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

   regfile_mp #(
      .WORD_SIZE (WS),
      .NUM_REGS  (NR),
      .NUM_RD    (NRD),
      .NUM_WR    (NWR),
      .ZERO_REG  (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string         tag;
      int            kind;   // 0 = rd_data, 1 = rd_busy, 2 = init_done
      int            port;
      logic [WS-1:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int kind, input int port, input logic [WS-1:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.port = port;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t          e;
      logic [WS-1:0] obs;
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            0:       obs = bus.rd_data[e.port*WS +: WS];
            1:       obs = {{(WS-1){1'b0}}, bus.rd_busy[e.port]};
            default: obs = {{(WS-1){1'b0}}, bus.init_done};
         endcase
         n_checks++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      bus.wr_en       = 2'b00;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.sb_set_en   = 1'b0;
      bus.sb_set_addr = 5'd0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      bus.rd_addr = {5'(a1), 5'(a0)};
   endtask

   task automatic wr(input int p, input int addr, input logic [WS-1:0] data);
      bus.wr_en[p]             = 1'b1;
      bus.wr_addr[p*AW +: AW]  = 5'(addr);
      bus.wr_data[p*WS +: WS]  = data;
   endtask

   // 32 cycles of init_done low with writes/sets hammering already-cleared slots, then high.
   task automatic sweep_check(input string tag);
      for (int c = 0; c < NR; c++) begin
         push({tag, "_done_low"}, 2, 0, 32'd0);
         push({tag, "_sweep_busy"}, 1, 0, 32'd0);
         bus.wr_en       = 2'b11;
         bus.wr_addr     = {5'((c + 30) % NR), 5'((c + 31) % NR)};
         bus.wr_data     = {32'hBAD00000 + 32'(c), 32'hFACE0000 + 32'(c)};
         bus.sb_set_en   = 1'b1;
         bus.sb_set_addr = 5'((c + 31) % NR);
         set_rd((c + 31) % NR, 3);
         drain();
         tick();
      end
      idle();
      push({tag, "_done_high"}, 2, 0, 32'd1);
      drain();
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < NR; i++) begin
         set_rd(i, NR - 1 - i);
         push({tag, "_data0"}, 0, 0, 32'd0);
         push({tag, "_data1"}, 0, 1, 32'd0);
         push({tag, "_busy0"}, 1, 0, 32'd0);
         push({tag, "_busy1"}, 1, 1, 32'd0);
         drain();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bus.rd_addr = '0;
      tick();
      rst = 1'b0;

      push("reset_done", 2, 0, 32'd0);
      push("reset_rd_data", 0, 0, 32'd0);
      push("reset_rd_busy", 1, 1, 32'd0);
      drain();

      sweep_check("sweep1");
      read_all_zero("after_sweep1");

      // x5 write, visible next cycle
      wr(0, 5, 32'hDEADBEEF);
      set_rd(5, 5);
      tick();
      idle();
      push("x5_rd0", 0, 0, 32'hDEADBEEF);
      push("x5_rd1", 0, 1, 32'hDEADBEEF);
      drain();

      // x0 is hardwired to zero, with or without forwarding
      wr(0, 0, 32'h00001234);
      set_rd(0, 5);
      push("x0_same_cycle", 0, 0, 32'd0);
      drain();
      tick();
      idle();
      push("x0_after", 0, 0, 32'd0);
      push("x5_kept", 0, 1, 32'hDEADBEEF);
      drain();

      // both write ports to x7: port 1 wins
      wr(0, 7, 32'h00000011);
      wr(1, 7, 32'h00000022);
      set_rd(7, 5);
      tick();
      idle();
      push("x7_dual_write", 0, 0, 32'h00000022);
      drain();

      // scoreboard set on x9
      bus.sb_set_en   = 1'b1;
      bus.sb_set_addr = 5'd9;
      set_rd(9, 0);
      push("x9_busy_before", 1, 0, 32'd0);
      drain();
      tick();
      idle();
      push("x9_busy_set", 1, 0, 32'd1);
      drain();

      // write to x9 retires it
      wr(1, 9, 32'h00000099);
`ifdef RF_BYPASS_EN
      push("x9_busy_fwd", 1, 0, 32'd0);
      push("x9_data_fwd", 0, 0, 32'h00000099);
`else
      push("x9_busy_fwd", 1, 0, 32'd1);
      push("x9_data_fwd", 0, 0, 32'd0);
`endif
      drain();
      tick();
      idle();
      push("x9_busy_clear", 1, 0, 32'd0);
      push("x9_data", 0, 0, 32'h00000099);
      drain();

      // set and clear of x9 together: set wins
      wr(0, 9, 32'h00000999);
      bus.sb_set_en   = 1'b1;
      bus.sb_set_addr = 5'd9;
      tick();
      idle();
      push("x9_set_wins", 1, 0, 32'd1);
      push("x9_data2", 0, 0, 32'h00000999);
      drain();

      // x0 is never busy
      bus.sb_set_en   = 1'b1;
      bus.sb_set_addr = 5'd0;
      tick();
      idle();
      set_rd(0, 9);
      push("x0_never_busy", 1, 0, 32'd0);
      push("x9_still_busy", 1, 1, 32'd1);
      drain();

      // same-cycle read of a register being written
      wr(1, 3, 32'h00000033);
      tick();
      idle();
      wr(0, 3, 32'hA5A5A5A5);
      set_rd(5, 3);
`ifdef RF_BYPASS_EN
      push("x3_same_cycle", 0, 1, 32'hA5A5A5A5);
`else
      push("x3_same_cycle", 0, 1, 32'h00000033);
`endif
      drain();
      tick();
      idle();
      push("x3_next_cycle", 0, 1, 32'hA5A5A5A5);
      drain();

      // reset mid-sweep at index 12 restarts the sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
      end
      push("midsweep_done_low", 2, 0, 32'd0);
      drain();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sweep_check("sweep2");
      read_all_zero("after_sweep2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation RISC-V core.
- Supports N read ports, M write ports and a per-register pending-write scoreboard for issue/hazard logic.
- After reset, a sequential clear sweep initialises the storage.
- Sits between decode (reads, scoreboard set) and writeback (write ports, scoreboard clear).

Parameters:
- WORD_SIZE, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- NUM_WR, 1, number of write ports, 1..2.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.
- AW, derived as $clog2(NUM_REGS); localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*WORD_SIZE  packed read data, combinational.
- rd_busy  out  NUM_RD  pending-write flag of each read address.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  packed write addresses.
- wr_data  in  NUM_WR*WORD_SIZE  packed write data.
- sb_set_en  in  1  mark register sb_set_addr pending.
- sb_set_addr  in  AW  register to mark pending.
- init_done  out  1  high once the clear sweep has finished; held until the next rst.

Behaviour:
- FSM states: CLEAR, READY.
- rst high at a clock edge:
  - state <= CLEAR, clear index <= 0.
  - All busy bits <= 0; init_done <= 0.
  - Applies from any state, including mid-sweep (sweep restarts at index 0).
- CLEAR:
  - Each cycle, register[index] <= 0 and index increments.
  - When index == NUM_REGS-1, that register is cleared and state <= READY.
  - init_done goes high the cycle after the last clear, i.e. NUM_REGS cycles after rst deasserts.
  - wr_en and sb_set_en are ignored.
  - rd_data reads all zeros; rd_busy reads all zeros.
- READY, reads:
  - rd_data[k] = register[rd_addr[k]], combinational, no latency.
  - With ZERO_REG=1, address 0 returns 0.
- READY, writes:
  - On a clock edge, for each j with wr_en[j], register[wr_addr[j]] <= wr_data[j].
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Two write ports to the same address in one cycle: the higher port index wins.
- Scoreboard (READY only):
  - sb_set_en sets busy[sb_set_addr].
  - Any write port with wr_en clears busy[wr_addr].
  - Set and clear of the same register in the same cycle: set wins, because the new producer supersedes the retiring one.
  - rd_busy[k] = busy[rd_addr[k]], combinational, reflecting the registered state only.
  - Register 0 is never busy when ZERO_REG=1.
- Read of a register being written in the same cycle returns the old value (no forwarding), unless RF_BYPASS_EN is defined.
- Widths: no arithmetic; all addresses are AW bits, so out-of-range addressing cannot occur.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - In READY, rd_data[k] and rd_busy[k] forward same-cycle writes.
  - If some wr_en[j] && wr_addr[j] == rd_addr[k] (and the address is nonzero when ZERO_REG=1), rd_data[k] = wr_data[j], highest j winning.
  - rd_busy[k] = 0 unless sb_set_en targets the same address, in which case rd_busy[k] = 1.
  - Write-to-read latency becomes 0 cycles.
- Undefined:
  - Reads see storage only; write-to-read latency is 1 cycle.
  - rd_busy reflects registered busy bits only.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants: XLEN = 32, NUM_ARCH_REGS = 32, REG_ZERO = 0;
  - the state enum for CLEAR/READY;
  - a function for packed-bus slicing.
- One sub-module, regfile_init_seq:
  - contains the CLEAR/READY FSM and the clear index counter;
  - outputs clear_en, clear_addr and init_done.
- The storage array, port muxing and scoreboard stay in regfile_mp.

Test Plan:
- Hold rst 1 cycle then release, with defaults -> init_done low for exactly 32 cycles, then high; every register reads 0; wr_en pulses during the sweep have no effect.
- In READY, write 0xDEADBEEF to x5, then read x5 next cycle -> 0xDEADBEEF. Write 0x1234 to x0 -> x0 still reads 0.
- With NUM_WR=2, both ports write x7 (0x11 on port 0, 0x22 on port 1) in one cycle -> x7 reads 0x22.
- sb_set_en with addr 9 -> rd_busy high for x9 the next cycle. wr_en to x9 -> busy clears. Simultaneous set of 9 and write of 9 -> busy remains 1.
- Assert rst at sweep index 12 -> index restarts at 0; init_done rises 32 cycles after the release.
- With RF_BYPASS_EN, write 0xA5A5A5A5 to x3 while reading x3 in the same cycle -> rd_data shows 0xA5A5A5A5 that cycle. Without the macro -> old value that cycle.
